fp_normalize: RTL and testbench

Final stage of the float32 adder pipeline. Consumes the Align_in record produced by the operate stage: resolved sign, provisional exponent, and 25-bit mantissa with carry bit [24] and hidden bit [23]. It normalizes the mantissa iteratively, one step per cycle, handles the carry, zero, subnormal, overflow and Inf/NaN cases, and emits a packed Float32. Valid/ready handshakes are used on both sides.

---
 rtl/fp_normalize_pkg.sv | 36 +++
 rtl/fp_norm_lzc.sv | 21 ++
 rtl/fp_normalize.sv | 128 ++++++++++++
 tb/tb_fp_normalize.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_normalize_pkg.sv
// Shared types for the float32 adder normalize stage: input record, output float,
// state encoding and optional status flags.
package fp_normalize_pkg;

  localparam logic [7:0] EXP_MAX    = 8'hFF;
  localparam int         MNT_HIDDEN = 23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } Norm_state;

  // mnt[24] is the carry out of the operate stage, mnt[23] the hidden bit
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mnt;
    logic        op;
    logic        flip;
  } Align_in;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } Float32;

  typedef struct packed {
    logic overflow;
    logic zero;
    logic subnormal;
    logic nan_inf;
  } Norm_flags;

endpackage

// File: rtl/fp_norm_lzc.sv
// Leading-zero counter over a 24-bit mantissa, saturating at SHIFT_STEP so the
// result is directly usable as a per-cycle shift amount.
module fp_norm_lzc #(
  parameter int SHIFT_STEP = 1
) (
  input  logic [23:0] mnt,
  output logic [2:0]  count
);

  // Only the top SHIFT_STEP bits matter; the rest are folded here so the port stays fully used
  logic unused_low;
  assign unused_low = ^mnt;

  always_comb begin
    count = 3'(SHIFT_STEP);
    for (int i = SHIFT_STEP - 1; i >= 0; i--) begin
      if (mnt[23 - i]) count = 3'(i);
    end
  end

endmodule

// File: rtl/fp_normalize.sv
// Float32 adder final stage: iterative normalization with valid/ready on both sides.
// Optional status flags output is enabled with `define FP_NORM_FLAGS_EN.
module fp_normalize
  import fp_normalize_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  output logic      in_ready,
  input  Align_in   in_data,
  output logic      out_valid,
  input  logic      out_ready,
  output Float32    out_result
`ifdef FP_NORM_FLAGS_EN
  , output Norm_flags out_flags
`endif
);

  if (!(SHIFT_STEP == 1 || SHIFT_STEP == 2 || SHIFT_STEP == 4)) begin : g_bad_step
    $error("fp_normalize: SHIFT_STEP must be 1, 2 or 4");
  end

  Norm_state   state;
  logic        r_sign;
  logic [7:0]  r_exp;
  logic [24:0] r_mnt;
  Float32      result_q;

  logic [2:0]  lz;
  logic [2:0]  k;
  logic [7:0]  exp_m1;
  logic [7:0]  exp_inc;

  logic        is_naninf;
  logic        is_zero;
  logic        is_carry;
  logic        is_ovf;
  logic        is_norm;
  logic        is_sub;
  logic        finish;
  Float32      nxt_result;

  logic        unused_fields;
  assign unused_fields = ^{in_data.op, in_data.flip};

  fp_norm_lzc #(.SHIFT_STEP(SHIFT_STEP)) u_lzc (
    .mnt   (r_mnt[23:0]),
    .count (lz)
  );

  // Shift never takes the exponent below 1, so the decrement cannot wrap
  assign exp_m1  = r_exp - 8'd1;
  assign exp_inc = r_exp + 8'd1;
  assign k       = (exp_m1 < {5'd0, lz}) ? exp_m1[2:0] : lz;

  assign is_naninf = (r_exp == EXP_MAX);
  assign is_zero   = !is_naninf && (r_mnt == 25'd0);
  assign is_carry  = !is_naninf && !is_zero && r_mnt[24];
  assign is_ovf    = is_carry && (exp_inc == EXP_MAX);
  assign is_norm   = !is_naninf && !is_zero && !is_carry && r_mnt[MNT_HIDDEN];
  assign is_sub    = !is_naninf && !is_zero && !is_carry && !is_norm && (r_exp <= 8'd1);
  assign finish    = is_naninf || is_zero || is_carry || is_norm || is_sub;

  always_comb begin
    nxt_result = '0;
    if (is_naninf)     nxt_result = '{sign: r_sign, exp: EXP_MAX, frac: r_mnt[22:0]};
    else if (is_zero)  nxt_result = '0;
    else if (is_ovf)   nxt_result = '{sign: r_sign, exp: EXP_MAX, frac: 23'd0};
    else if (is_carry) nxt_result = '{sign: r_sign, exp: exp_inc, frac: r_mnt[23:1]};
    else if (is_norm)  nxt_result = '{sign: r_sign, exp: r_exp, frac: r_mnt[22:0]};
    else if (is_sub)   nxt_result = '{sign: r_sign, exp: 8'h00, frac: r_mnt[22:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      r_sign   <= 1'b0;
      r_exp    <= 8'd0;
      r_mnt    <= 25'd0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r_sign <= in_data.sign;
            r_exp  <= in_data.exp;
            r_mnt  <= in_data.mnt;
            state  <= NORM;
          end
        end
        NORM: begin
          if (finish) begin
            result_q <= nxt_result;
            state    <= DONE;
          end else begin
            r_mnt <= r_mnt << k;
            r_exp <= r_exp - {5'd0, k};
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FP_NORM_FLAGS_EN
  Norm_flags flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (state == NORM && finish) begin
      flags_q <= '{overflow: is_ovf, zero: is_zero, subnormal: is_sub, nan_inf: is_naninf};
    end
  end

  assign out_flags = flags_q;
`endif

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign out_result = result_q;

endmodule

// File: tb/tb_fp_normalize.sv
// Scoreboard bench for fp_normalize: one instance with SHIFT_STEP=1 and one with
// SHIFT_STEP=4, hand-derived expected results and latencies.
module tb_fp_normalize;
  import fp_normalize_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  Align_in in_data;
  logic    out_ready;

  logic    in_valid_a, in_ready_a, out_valid_a;
  logic    in_valid_b, in_ready_b, out_valid_b;
  Float32  out_result_a, out_result_b;
`ifdef FP_NORM_FLAGS_EN
  Norm_flags out_flags_a, out_flags_b;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fp_normalize #(.SHIFT_STEP(1)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid_a),
    .in_ready   (in_ready_a),
    .in_data    (in_data),
    .out_valid  (out_valid_a),
    .out_ready  (out_ready),
    .out_result (out_result_a)
`ifdef FP_NORM_FLAGS_EN
    , .out_flags (out_flags_a)
`endif
  );

  fp_normalize #(.SHIFT_STEP(4)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid_b),
    .in_ready   (in_ready_b),
    .in_data    (in_data),
    .out_valid  (out_valid_b),
    .out_ready  (out_ready),
    .out_result (out_result_b)
`ifdef FP_NORM_FLAGS_EN
    , .out_flags (out_flags_b)
`endif
  );

  typedef struct {
    logic [31:0] result;
    logic [3:0]  flags;
    int          lat;
  } exp_t;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mnt;
    logic [31:0] result;
    logic [3:0]  flags;
    int          lat1;
    int          lat4;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[13];

  int check_count = 0;
  int pass_count  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    check_count++;
    if (got === want) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
  endtask

  function automatic logic sel_ready(input int which);
    return (which == 0) ? in_ready_a : in_ready_b;
  endfunction

  function automatic logic sel_valid(input int which);
    return (which == 0) ? out_valid_a : out_valid_b;
  endfunction

  function automatic logic [31:0] sel_result(input int which);
    return (which == 0) ? out_result_a : out_result_b;
  endfunction

`ifdef FP_NORM_FLAGS_EN
  function automatic logic [3:0] sel_flags(input int which);
    return (which == 0) ? out_flags_a : out_flags_b;
  endfunction
`endif

  task automatic drive_input(input logic sign, input logic [7:0] exp, input logic [24:0] mnt);
    in_data = '{sign: sign, exp: exp, mnt: mnt, op: 1'($urandom), flip: 1'($urandom)};
  endtask

  // Drive one operation, push its expectation, then wait for and retire the result
  task automatic applyStimulus(input int which, input string tag, input logic sign,
                               input logic [7:0] exp, input logic [24:0] mnt,
                               input logic [31:0] want, input logic [3:0] want_flags,
                               input int want_lat);
    exp_t e;
    int   t_acc;
    int   waited;
    int   lat;
    @(negedge clk);
    waited = 0;
    while (!sel_ready(which) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    drive_input(sign, exp, mnt);
    if (which == 0) in_valid_a = 1'b1;
    else            in_valid_b = 1'b1;
    sb.push_back('{result: want, flags: want_flags, lat: want_lat});
    t_acc = cyc + 1;
    @(negedge clk);
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    waited = 0;
    while (!sel_valid(which) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    lat = cyc - t_acc + 1;
    e = sb.pop_front();
    checkOutput({tag, "/result"}, sel_result(which), e.result);
    checkOutput({tag, "/latency"}, 32'(lat), 32'(e.lat));
`ifdef FP_NORM_FLAGS_EN
    checkOutput({tag, "/flags"}, {28'd0, sel_flags(which)}, {28'd0, e.flags});
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   t_acc;
    int   waited;
    logic saw;

    //          sign  exp    mnt           result        flags    lat1 lat4
    vecs[0]  = '{1'b0, 8'h7F, 25'h0800000, 32'h3F800000, 4'b0000, 2,  2};
    vecs[1]  = '{1'b0, 8'h7F, 25'h1000000, 32'h40000000, 4'b0000, 2,  2};
    vecs[2]  = '{1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 4'b1000, 2,  0};
    vecs[3]  = '{1'b0, 8'h80, 25'h0200000, 32'h3F000000, 4'b0000, 4,  3};
    vecs[4]  = '{1'b1, 8'h55, 25'h0000000, 32'h00000000, 4'b0100, 2,  0};
    vecs[5]  = '{1'b0, 8'h02, 25'h0200000, 32'h00400000, 4'b0010, 3,  3};
    vecs[6]  = '{1'b1, 8'hFF, 25'h0400001, 32'hFFC00001, 4'b0001, 2,  0};
    vecs[7]  = '{1'b1, 8'h81, 25'h17FFFFF, 32'hC13FFFFF, 4'b0000, 2,  0};
    vecs[8]  = '{1'b0, 8'h01, 25'h0400000, 32'h00400000, 4'b0010, 2,  0};
    vecs[9]  = '{1'b0, 8'h05, 25'h0000001, 32'h00000010, 4'b0010, 6,  3};
    vecs[10] = '{1'b0, 8'h90, 25'h0000010, 32'h3E800000, 4'b0000, 21, 7};
    vecs[11] = '{1'b0, 8'h7F, 25'h0FFFFFF, 32'h3FFFFFFF, 4'b0000, 2,  0};
    vecs[12] = '{1'b0, 8'h03, 25'h0000100, 32'h00000400, 4'b0010, 4,  3};

    rst        = 1'b1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    out_ready  = 1'b0;
    drive_input(1'b0, 8'h00, 25'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset/result", out_result_a, 32'h0);
    checkOutput("reset/out_valid", {31'd0, out_valid_a}, 32'd0);
    checkOutput("reset/in_ready", {31'd0, in_ready_a}, 32'd1);
    checkOutput("reset/result_b", out_result_b, 32'h0);

    $display("[TB] vector table");
    foreach (vecs[i]) begin
      applyStimulus(0, $sformatf("s1_v%0d", i), vecs[i].sign, vecs[i].exp, vecs[i].mnt,
                    vecs[i].result, vecs[i].flags, vecs[i].lat1);
      if (vecs[i].lat4 != 0)
        applyStimulus(1, $sformatf("s4_v%0d", i), vecs[i].sign, vecs[i].exp, vecs[i].mnt,
                      vecs[i].result, vecs[i].flags, vecs[i].lat4);
    end

    $display("[TB] backpressure hold");
    @(negedge clk);
    drive_input(1'b0, 8'h7F, 25'h0800000);
    in_valid_a = 1'b1;
    @(negedge clk);
    in_valid_a = 1'b0;
    @(negedge clk);
    drive_input(1'b0, 8'h7F, 25'h1000000);
    in_valid_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("hold%0d/result", i), out_result_a, 32'h3F800000);
      checkOutput($sformatf("hold%0d/out_valid", i), {31'd0, out_valid_a}, 32'd1);
      checkOutput($sformatf("hold%0d/in_ready", i), {31'd0, in_ready_a}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("handoff/out_valid", {31'd0, out_valid_a}, 32'd0);
    checkOutput("handoff/in_ready", {31'd0, in_ready_a}, 32'd1);
    t_acc = cyc + 1;
    @(negedge clk);
    in_valid_a = 1'b0;
    waited = 0;
    while (!out_valid_a && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("second/result", out_result_a, 32'h40000000);
    checkOutput("second/latency", 32'(cyc - t_acc + 1), 32'd2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    $display("[TB] reset during NORM");
    drive_input(1'b0, 8'h90, 25'h0000008);
    in_valid_a = 1'b1;
    @(negedge clk);
    in_valid_a = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst/out_valid", {31'd0, out_valid_a}, 32'd0);
    checkOutput("rst/in_ready", {31'd0, in_ready_a}, 32'd1);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid_a) saw = 1'b1;
    end
    checkOutput("rst/no_stale", {31'd0, saw}, 32'd0);
    applyStimulus(0, "after_rst", 1'b0, 8'h80, 25'h0200000, 32'h3F000000, 4'b0000, 4);

    checkOutput("scoreboard/empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
